// File: rtl/quant_stream_if.sv
// Streaming handshake bundle for quant_stream: coefficient input, table select and quantized output.
// master = upstream/downstream environment view, slave = quantizer view.
interface quant_stream_if #(
  parameter int W  = 16,
  parameter int WN = 8
);
  logic [1:0]           qsel;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [WN-1:0] out_data;
  logic [5:0]           out_pos;
  logic                 out_last;
  logic                 out_sat;

  modport master (
    output qsel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_pos, out_last, out_sat
  );

  modport slave (
    input  qsel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_pos, out_last, out_sat
  );
endinterface

// File: rtl/quant_stream.sv
// Two-stage streaming JPEG quantizer: per-position power-of-two shift from one of four tables, then clamp.
// Optional macro QUANT_ROUND_EN enables round-half-away-from-zero; default is floor (arithmetic shift).
module quant_stream #(
  parameter int W  = 16,
  parameter int WN = 8
) (
  input  logic          clk,
  input  logic          rst,
  quant_stream_if.slave bus
);

  localparam logic signed [W:0] Q_MAX = (W+1)'((1 << (WN-1)) - 1);
  localparam logic signed [W:0] Q_MIN = ~Q_MAX;

  // Standard table, one 32-bit word per row, column 0 in the low nibble.
  function automatic logic [3:0] base_shift(input logic [5:0] p);
    logic [31:0] row;
    case (p[5:3])
      3'd0:    row = 32'h66554334;
      3'd1:    row = 32'h66654433;
      3'd2:    row = 32'h66655444;
      3'd3:    row = 32'h66665444;
      3'd4:    row = 32'h67766544;
      3'd5:    row = 32'h67766654;
      3'd6:    row = 32'h77777665;
      default: row = 32'h77777776;
    endcase
    return row[{p[2:0], 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] shift_lookup(input logic [1:0] t, input logic [5:0] p);
    logic [3:0] b;
    b = base_shift(p);
    case (t)
      2'd0:    return b;
      2'd1:    return (b == 4'd0) ? 4'd0 : b - 4'd1;
      2'd2:    return (b >= 4'd8) ? 4'd8 : b + 4'd1;
      default: return 4'd4;
    endcase
  endfunction

  // One extra bit of headroom so the rounding bias can never wrap.
  function automatic logic signed [W:0] shift_round(input logic signed [W-1:0] x, input logic [3:0] s);
    logic signed [W:0] xe;
    logic signed [W:0] bias;
    xe   = {x[W-1], x};
    bias = '0;
`ifdef QUANT_ROUND_EN
    if (s != 4'd0) begin
      bias = (W+1)'(1) << (s - 4'd1);
      if (x[W-1]) bias = bias - (W+1)'(1);
    end
`endif
    return (xe + bias) >>> s;
  endfunction

  // Returns {saturated, value}.
  function automatic logic [WN:0] clamp_sat(input logic signed [W:0] q);
    if (q > Q_MAX) return {1'b1, Q_MAX[WN-1:0]};
    if (q < Q_MIN) return {1'b1, Q_MIN[WN-1:0]};
    return {1'b0, q[WN-1:0]};
  endfunction

  logic [5:0]           pos;
  logic [1:0]           tsel;
  logic                 adv;
  logic                 acc;
  logic [1:0]           tsel_cur;
  logic [3:0]           s_p0;
  logic signed [W:0]    q_p0;

  logic                 vld_p1;
  logic [5:0]           pos_p1;
  logic                 last_p1;
  logic signed [W:0]    q_p1;
  logic [WN:0]          clamp_p1;

  logic                 vld_p2;
  logic [5:0]           pos_p2;
  logic                 last_p2;
  logic                 sat_p2;
  logic signed [WN-1:0] data_p2;

  assign adv      = !vld_p2 || bus.out_ready;
  assign acc      = bus.in_valid && adv;
  // At position 0 the incoming select is the one being latched, so use it directly.
  assign tsel_cur = (pos == 6'd0) ? bus.qsel : tsel;
  assign s_p0     = shift_lookup(tsel_cur, pos);
  assign q_p0     = shift_round(bus.in_data, s_p0);
  assign clamp_p1 = clamp_sat(q_p1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos    <= '0;
      tsel   <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= acc;
      vld_p2 <= vld_p1;
      if (acc) begin
        pos <= pos + 6'd1;
        if (pos == 6'd0) tsel <= bus.qsel;
      end
    end
  end

  // Stage 0 -> 1: shift (with optional rounding bias)
  always_ff @(posedge clk) begin
    if (adv) begin
      q_p1    <= q_p0;
      pos_p1  <= pos;
      last_p1 <= (pos == 6'd63);
    end
  end

  // Stage 1 -> 2: clamp to output width
  always_ff @(posedge clk) begin
    if (adv) begin
      data_p2 <= clamp_p1[WN-1:0];
      sat_p2  <= clamp_p1[WN];
      pos_p2  <= pos_p1;
      last_p2 <= last_p1;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_p2;
  assign bus.out_data  = vld_p2 ? data_p2 : '0;
  assign bus.out_pos   = vld_p2 ? pos_p2  : '0;
  assign bus.out_last  = vld_p2 && last_p2;
  assign bus.out_sat   = vld_p2 && sat_p2;

endmodule

// File: tb/tb_quant_stream.sv
// Randomized bench for quant_stream against an arithmetic reference model (scoreboard queue).
// Compile with +define+QUANT_ROUND_EN to check the rounding build.
module tb_quant_stream;
  localparam int W  = 16;
  localparam int WN = 8;
`ifdef QUANT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quant_stream_if #(.W(W), .WN(WN)) bus ();
  quant_stream #(.W(W), .WN(WN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    longint data;
    int     pos;
    bit     last;
    bit     sat;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];
  int mpos, mtsel, cyc, n_last, first_acc, first_vld;
  bit rdy_rand, gap_rand, stalled_prev;
  longint prev_data;
  int prev_pos;
  bit prev_last, prev_sat;
  longint cap_data[64];
  bit cap_last[64], cap_sat[64];
  int force_val[64];
  bit force_en[64];

  int t0[64] = '{4,3,3,4,5,5,6,6,  3,3,4,4,5,6,6,6,  4,4,4,5,5,6,6,6,  4,4,4,5,6,6,6,6,
                 4,4,5,6,6,7,7,6,  4,5,6,6,6,7,7,6,  5,6,6,7,7,7,7,7,  6,7,7,7,7,7,7,7};

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_shift(int t, int p);
    int b = t0[p];
    case (t)
      0:       return b;
      1:       return (b > 0) ? b - 1 : 0;
      2:       return (b < 8) ? b + 1 : 8;
      default: return 4;
    endcase
  endfunction

  // Division by 2^s: floor, or round half away from zero.
  function automatic longint quant_ref(longint x, int s);
    longint d = longint'(1) << s;
    longint h = (s > 0) ? d / 2 : 0;
    if (RND) return (x >= 0) ? (x + h) / d : -((-x + h) / d);
    return (x >= 0) ? x / d : -((-x + d - 1) / d);
  endfunction

  function automatic int rand_coef();
    if ($urandom_range(0, 3) == 0) return int'($signed(16'($urandom)));
    return int'($urandom_range(0, 1200)) - 600;
  endfunction

  task automatic step(input logic v, input logic signed [W-1:0] d, input logic [1:0] q, output bit acc);
    exp_t e;
    longint hi, lo, qv;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.qsel      = q;
    bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
    if (stalled_prev) begin
      check("hold_vld",  bus.out_valid, 1);
      check("hold_data", longint'(bus.out_data), prev_data);
      check("hold_pos",  bus.out_pos, prev_pos);
      check("hold_last", bus.out_last, prev_last);
      check("hold_sat",  bus.out_sat, prev_sat);
    end
    if (bus.out_valid && first_vld < 0) first_vld = cyc;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_data", longint'(bus.out_data), e.data);
        check("out_pos",  bus.out_pos, e.pos);
        check("out_last", bus.out_last, e.last);
        check("out_sat",  bus.out_sat, e.sat);
      end
      cap_data[bus.out_pos] = longint'(bus.out_data);
      cap_last[bus.out_pos] = bus.out_last;
      cap_sat[bus.out_pos]  = bus.out_sat;
      if (bus.out_last) n_last++;
    end
    acc = v && bus.in_ready;
    if (acc) begin
      if (first_acc < 0) first_acc = cyc;
      if (mpos == 0) mtsel = int'(q);
      hi = (longint'(1) << (WN - 1)) - 1;
      lo = -(longint'(1) << (WN - 1));
      qv = quant_ref(longint'(d), ref_shift(mtsel, mpos));
      e.sat = (qv > hi) || (qv < lo);
      e.data = (qv > hi) ? hi : (qv < lo) ? lo : qv;
      e.pos = mpos;
      e.last = (mpos == 63);
      sb.push_back(e);
      mpos = (mpos + 1) % 64;
    end
    stalled_prev = bus.out_valid && !bus.out_ready;
    prev_data = longint'(bus.out_data);
    prev_pos  = int'(bus.out_pos);
    prev_last = bus.out_last;
    prev_sat  = bus.out_sat;
    cyc++;
  endtask

  task automatic clear_force();
    for (int i = 0; i < 64; i++) force_en[i] = 1'b0;
  endtask

  task automatic begin_block();
    for (int i = 0; i < 64; i++) begin
      cap_data[i] = -99999;
      cap_last[i] = 1'b0;
      cap_sat[i]  = 1'b0;
    end
    n_last = 0;
  endtask

  // Send n coefficients starting at position 0; qsel is q0 before index sw, q1 from sw on.
  task automatic send(input int n, input int q0, input int q1, input int sw);
    for (int k = 0; k < n; k++) begin
      int d, tries;
      bit acc, v;
      d = force_en[k] ? force_val[k] : rand_coef();
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 1000) begin
        v = gap_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        step(v, W'(d), 2'((k < sw) ? q0 : q1), acc);
        tries++;
      end
      if (!acc) begin
        check("accept_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic drain();
    bit acc;
    int guard = 0;
    while ((sb.size() != 0 || bus.out_valid) && guard < 500) begin
      step(1'b0, '0, 2'd0, acc);
      guard++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int sat_in[3]  = '{32767, -32768, 400};
    int sat_exp[3] = '{127, -128, 100};
    int sat_flg[3] = '{1, 1, 0};
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.qsel = 2'd0; bus.out_ready = 1'b1;
    mpos = 0; mtsel = 0; cyc = 0; stalled_prev = 1'b0; rdy_rand = 1'b0; gap_rand = 1'b0;
    first_acc = -1; first_vld = -1;
    clear_force();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  longint'(bus.out_data), 0);
    check("rst_out_pos",   bus.out_pos, 0);
    check("rst_out_last",  bus.out_last, 0);
    check("rst_out_sat",   bus.out_sat, 0);
    check("rst_in_ready",  bus.in_ready, 1);

    // Constant 100, table 0
    begin_block();
    for (int i = 0; i < 64; i++) begin force_en[i] = 1'b1; force_val[i] = 100; end
    send(64, 0, 0, 64);
    drain();
    check("c100_p0",  cap_data[0],  RND ? 6 : 6);
    check("c100_p1",  cap_data[1],  RND ? 13 : 12);
    check("c100_p7",  cap_data[7],  RND ? 2 : 1);
    check("c100_p63", cap_data[63], RND ? 1 : 0);
    check("c100_last63", cap_last[63], 1);
    check("c100_nlast",  n_last, 1);
    check("latency", first_vld - first_acc, 2);

    // Rounding signs, flat table
    clear_force(); begin_block();
    force_en[0] = 1; force_val[0] = 24;
    force_en[1] = 1; force_val[1] = -24;
    force_en[2] = 1; force_val[2] = -8;
    force_en[3] = 1; force_val[3] = 7;
    send(64, 3, 3, 64);
    drain();
    check("rnd_p24", cap_data[0], RND ? 2 : 1);
    check("rnd_m24", cap_data[1], -2);
    check("rnd_m8",  cap_data[2], -1);
    check("rnd_p7",  cap_data[3], 0);

    // Saturation at position 1 of the fine table
    for (int t = 0; t < 3; t++) begin
      clear_force(); begin_block();
      force_en[1] = 1; force_val[1] = sat_in[t];
      send(64, 1, 1, 64);
      drain();
      check("sat_data", cap_data[1], sat_exp[t]);
      check("sat_flag", cap_sat[1], sat_flg[t]);
    end

    // Random backpressure and input gaps over three blocks
    clear_force(); begin_block();
    rdy_rand = 1'b1; gap_rand = 1'b1;
    for (int b = 0; b < 3; b++) send(64, int'($urandom_range(0, 3)), 0, 64);
    drain();
    check("bp_nlast", n_last, 3);
    rdy_rand = 1'b0; gap_rand = 1'b0;

    // qsel change mid-block latches only at the next block
    clear_force(); begin_block();
    force_en[40] = 1; force_val[40] = 256;
    send(64, 0, 2, 30);
    drain();
    check("latch_same_block", cap_data[40], 16);
    clear_force(); begin_block();
    force_en[0] = 1; force_val[0] = 256;
    send(64, 2, 2, 64);
    drain();
    check("latch_next_block", cap_data[0], 8);

    // Reset with data in flight
    clear_force(); begin_block();
    send(41, 1, 1, 64);
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready",  bus.in_ready, 1);
    sb.delete();
    mpos = 0; mtsel = 0; stalled_prev = 1'b0;
    repeat (3) step(1'b0, '0, 2'd0, acc);
    begin_block();
    force_en[0] = 1; force_val[0] = 24;
    send(64, 3, 3, 64);
    drain();
    check("midrst_p0", cap_data[0], RND ? 2 : 1);
    check("midrst_nlast", n_last, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
